// File: rtl/debug_slave_ocimem_engine.sv
// debug_slave_ocimem_engine
// Sysclk-side executor for JTAG monitor-RAM accesses issued by the debug slave
// wrapper, with a secondary CPU read port that stalls while JTAG owns the RAM.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   jdo[37:0]                   wrapper data, valid while a take_* pulse is high
//   take_action_ocimem_a        load address (optionally read / clear error)
//   take_action_ocimem_b        write jdo[34:3] at the current address
//   take_no_action_ocimem_a     increment address and read
//   MonDReg                     last JTAG read data
//   monitor_ready               last JTAG operation complete
//   monitor_error               sticky error flag
//   cpu_address, cpu_read       CPU read request
//   cpu_waitrequest             CPU stall (combinational)
//   cpu_readdata                CPU read data
//   cpu_readdatavalid           one-cycle CPU data-valid pulse
module debug_slave_ocimem_engine #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_read,
  output logic          cpu_waitrequest,
  output logic [31:0]   cpu_readdata,
  output logic          cpu_readdatavalid
);

  localparam int unsigned MAW = 10;       // monitor address register width
  localparam int unsigned OW  = MAW + 1;  // width for the range comparison
  localparam int unsigned DW  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    RDCAP = 2'd2,
    WR    = 2'd3
  } state_t;

  state_t          state;
  logic [MAW-1:0]  mon_a_reg;
  logic [MAW-1:0]  mon_a_inc;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   ram_q;
  logic [DW-1:0]   mem [DEPTH];
  logic            cpu_pend;

  logic            any_take;
  logic            multi_take;
  logic            addr_oor;
  logic            cpu_accept;
  logic            jtag_rd_en;
  logic            jtag_wr_en;
  logic [AW-1:0]   ram_idx;
  logic            unused_jdo;

  // jdo bits outside the command fields carry nothing for this block
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign any_take   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_take = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                    | (take_action_ocimem_b & take_no_action_ocimem_a);

  // MonAReg is 10 bits wide but the RAM may be smaller
  assign addr_oor  = {1'b0, mon_a_reg} >= OW'(DEPTH);
  assign mon_a_inc = mon_a_reg + MAW'(1);
  assign ram_idx   = mon_a_reg[AW-1:0];

  // JTAG owns the RAM port in RD and WR; CPU reads are stalled only then
  assign cpu_waitrequest = cpu_read & ((state == RD) | (state == WR));
  assign cpu_accept      = cpu_read & ~cpu_waitrequest;

  assign jtag_rd_en = (state == RD) & ~addr_oor;
  assign jtag_wr_en = (state == WR) & ~addr_oor & ~reset;

  // Single-port monitor RAM with registered read, shared by JTAG and CPU
  always_ff @(posedge clk) begin
    if (jtag_wr_en) begin
      mem[ram_idx] <= wr_data;
    end
    if (jtag_rd_en) begin
      ram_q <= mem[ram_idx];
    end else if (cpu_accept) begin
      ram_q <= mem[cpu_address];
    end
  end

  // Command FSM, status outputs and CPU return path
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      mon_a_reg         <= '0;
      wr_data           <= '0;
      MonDReg           <= '0;
      monitor_ready     <= 1'b0;
      monitor_error     <= 1'b0;
      cpu_pend          <= 1'b0;
      cpu_readdatavalid <= 1'b0;
      cpu_readdata      <= '0;
    end else begin
      // CPU data returns one cycle after the RAM was read for it
      cpu_pend          <= cpu_accept;
      cpu_readdatavalid <= cpu_pend;
      if (cpu_pend) begin
        cpu_readdata <= ram_q;
      end

      unique case (state)
        IDLE: begin
          if (take_action_ocimem_a) begin
            mon_a_reg     <= jdo[26:17];
            monitor_ready <= 1'b0;
            if (jdo[34]) begin
              state <= RD;
            end else begin
              monitor_ready <= 1'b1;
            end
            // an explicit clear wins over an error raised in the same cycle
            if (jdo[35]) begin
              monitor_error <= 1'b0;
            end else if (multi_take) begin
              monitor_error <= 1'b1;
            end
          end else if (take_action_ocimem_b) begin
            wr_data       <= jdo[34:3];
            monitor_ready <= 1'b0;
            state         <= WR;
            if (multi_take) begin
              monitor_error <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            mon_a_reg     <= mon_a_inc;
            monitor_ready <= 1'b0;
            state         <= RD;
          end
        end

        RD: begin
          if (any_take | addr_oor) begin
            monitor_error <= 1'b1;
          end
          state <= RDCAP;
        end

        RDCAP: begin
          if (any_take) begin
            monitor_error <= 1'b1;
          end
          if (!addr_oor) begin
            MonDReg <= ram_q;
          end
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end

        WR: begin
          if (any_take | addr_oor) begin
            monitor_error <= 1'b1;
          end
          mon_a_reg     <= mon_a_inc;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_slave_ocimem_engine.sv
// Self-checking bench for debug_slave_ocimem_engine: a queue-based scoreboard
// fed by a transaction-level model of the monitor RAM, address and flags.
module tb_debug_slave_ocimem_engine;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic          take_no_action_ocimem_a;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;
  logic [AW-1:0] cpu_address;
  logic          cpu_read;
  logic          cpu_waitrequest;
  logic [31:0]   cpu_readdata;
  logic          cpu_readdatavalid;

  debug_slave_ocimem_engine #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  int          ref_addr;
  bit          ref_err;
  logic [31:0] ref_dreg;
  bit          busy_at [int];   // cycles in which JTAG holds the RAM port

  typedef struct {
    int          due;
    bit          full;
    bit          rdy;
    bit          err;
    logic [31:0] dreg;
  } jexp_t;
  typedef struct {
    int          due;
    logic [31:0] data;
  } cexp_t;

  jexp_t jq[$];
  cexp_t cq[$];
  jexp_t je;
  cexp_t ce;

  task automatic push_j(input int due, input bit full, input bit rdy, input bit err,
                        input logic [31:0] d);
    jexp_t e;
    e.due = due; e.full = full; e.rdy = rdy; e.err = err; e.dreg = d;
    jq.push_back(e);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    while (jq.size() > 0 && jq[0].due <= cyc) begin
      je = jq.pop_front();
      if (je.due != cyc) chk("jtag_check_cycle", 32'(cyc), 32'(je.due));
      chk("monitor_ready", 32'(monitor_ready), 32'(je.rdy));
      if (je.full) begin
        chk("monitor_error", 32'(monitor_error), 32'(je.err));
        chk("MonDReg", MonDReg, je.dreg);
      end
    end
  end

  always @(negedge clk) begin
    if (cpu_readdatavalid === 1'b1) begin
      if (cq.size() == 0) begin
        chk("cpu_readdatavalid_unexpected", 32'(cpu_readdatavalid), 32'(0));
      end else begin
        ce = cq.pop_front();
        chk("cpu_valid_cycle", 32'(cyc), 32'(ce.due));
        chk("cpu_readdata", cpu_readdata, ce.data);
      end
    end else if (cq.size() > 0 && cq[0].due <= cyc) begin
      ce = cq.pop_front();
      chk("cpu_readdatavalid", 32'(cpu_readdatavalid), 32'(1));
    end
  end

  // ---------------- JTAG drivers ----------------
  function automatic logic [37:0] rnd38();
    return {6'($urandom()), $urandom()};
  endfunction

  function automatic logic [37:0] jdo_a(input int addr, input bit rd, input bit clr);
    logic [37:0] d;
    d = rnd38();
    d[26:17] = 10'(addr);
    d[34] = rd;
    d[35] = clr;
    return d;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] d;
    d = rnd38();
    d[34:3] = data;
    return d;
  endfunction

  task automatic start_pulse(input bit a, input bit b, input bit n, input logic [37:0] d,
                             output int e0);
    @(negedge clk);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = n;
    jdo = d;
    e0 = cyc + 1;
  endtask

  task automatic end_pulse();
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = rnd38();   // write data must already be captured
  endtask

  task automatic wait_until(input int due);
    while (cyc < due) @(negedge clk);
  endtask

  // model a read of ref_addr; ready low in between, result two cycles on
  task automatic model_read_pre(input int e0);
    busy_at[e0] = 1'b1;
    push_j(e0 + 1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic model_read_post(input int e0);
    if (ref_addr < int'(DEPTH)) ref_dreg = ref_mem[ref_addr];
    else ref_err = 1'b1;
    push_j(e0 + 2, 1'b1, 1'b1, ref_err, ref_dreg);
  endtask

  task automatic jtag_load(input int addr, input bit rd, input bit clr,
                           input bit coincide, input bit stray);
    int e0;
    start_pulse(1'b1, coincide, coincide, jdo_a(addr, rd, clr), e0);
    ref_addr = addr;
    if (clr) ref_err = 1'b0;
    else if (coincide) ref_err = 1'b1;
    if (!rd) begin
      push_j(e0, 1'b1, 1'b1, ref_err, ref_dreg);
      end_pulse();
    end else begin
      model_read_pre(e0);
      if (!stray) model_read_post(e0);
      end_pulse();
      if (stray) begin
        // a write command arriving mid-read is dropped and flagged
        take_action_ocimem_b = 1'b1;
        jdo = jdo_b(32'h0BAD_0BAD);
        ref_err = 1'b1;
        model_read_post(e0);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
      end
      wait_until(e0 + 2);
    end
  endtask

  task automatic jtag_write(input logic [31:0] data);
    int e0;
    start_pulse(1'b0, 1'b1, 1'b0, jdo_b(data), e0);
    busy_at[e0] = 1'b1;
    if (ref_addr < int'(DEPTH)) ref_mem[ref_addr] = data;
    else ref_err = 1'b1;
    ref_addr = (ref_addr + 1) % 1024;
    push_j(e0 + 1, 1'b1, 1'b1, ref_err, ref_dreg);
    end_pulse();
    wait_until(e0 + 1);
  endtask

  task automatic jtag_next();
    int e0;
    start_pulse(1'b0, 1'b0, 1'b1, rnd38(), e0);
    ref_addr = (ref_addr + 1) % 1024;
    model_read_pre(e0);
    model_read_post(e0);
    end_pulse();
    wait_until(e0 + 2);
  endtask

  // ---------------- CPU drivers ----------------
  task automatic cpu_cycle(input bit rd, input logic [AW-1:0] a, output bit accepted);
    bit exp_wait;
    @(negedge clk);
    cpu_read = rd;
    cpu_address = a;
    #1;
    exp_wait = rd && busy_at.exists(cyc);
    chk("cpu_waitrequest", 32'(cpu_waitrequest), 32'(exp_wait));
    accepted = rd && !exp_wait;
    if (accepted) begin
      ce.due = cyc + 2;
      ce.data = ref_mem[int'(a)];
      cq.push_back(ce);
    end
  endtask

  task automatic cpu_read_op(input logic [AW-1:0] a);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 8) begin
      cpu_cycle(1'b1, a, acc);
      tries++;
    end
    if (!acc) chk("cpu_accept_timeout", 32'(cpu_waitrequest), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    bit acc;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_read = 1'b0;
    cpu_address = '0;
    ref_addr = 0;
    ref_err = 1'b0;
    ref_dreg = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset_MonDReg", MonDReg, 32'h0);
    chk("reset_monitor_ready", 32'(monitor_ready), 32'(0));
    chk("reset_monitor_error", 32'(monitor_error), 32'(0));
    chk("reset_cpu_readdatavalid", 32'(cpu_readdatavalid), 32'(0));
    chk("reset_cpu_readdata", cpu_readdata, 32'h0);
    chk("reset_cpu_waitrequest", 32'(cpu_waitrequest), 32'(0));
    reset = 1'b0;

    // fill the whole RAM so every later read has a known value
    jtag_load(0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) jtag_write($urandom());

    // write then read back at address 5, plus increment to 6
    jtag_load(5, 1'b0, 1'b0, 1'b0, 1'b0);
    jtag_write(32'hDEAD_BEEF);
    jtag_write(32'hCAFE_0006);
    jtag_load(5, 1'b1, 1'b0, 1'b0, 1'b0);
    jtag_load(6, 1'b1, 1'b0, 1'b0, 1'b0);

    // sequential reads via read-next
    jtag_load(10, 1'b0, 1'b0, 1'b0, 1'b0);
    jtag_write(32'h1);
    jtag_write(32'h2);
    jtag_write(32'h3);
    jtag_load(9, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) jtag_next();

    // out-of-range read, then explicit clear
    jtag_load(300, 1'b1, 1'b0, 1'b0, 1'b0);
    jtag_load(20, 1'b0, 1'b1, 1'b0, 1'b0);

    // coinciding pulses: address command wins, error flagged
    jtag_load(12, 1'b1, 1'b0, 1'b1, 1'b0);
    jtag_load(12, 1'b0, 1'b1, 1'b0, 1'b0);
    // clear wins over a coincidence error in the same cycle
    jtag_load(13, 1'b1, 1'b1, 1'b1, 1'b0);

    // pulse while busy is dropped
    jtag_load(5, 1'b1, 1'b0, 1'b0, 1'b1);
    jtag_load(5, 1'b1, 1'b1, 1'b0, 1'b0);

    // out-of-range write at the top, address wraps to 0
    jtag_load(1023, 1'b0, 1'b1, 1'b0, 1'b0);
    jtag_write(32'h1234_5678);
    jtag_next();
    jtag_load(0, 1'b0, 1'b1, 1'b0, 1'b0);

    // CPU read held across a JTAG read
    start_pulse(1'b1, 1'b0, 1'b0, jdo_a(5, 1'b1, 1'b0), e0);
    ref_addr = 5;
    model_read_pre(e0);
    model_read_post(e0);
    end_pulse();
    cpu_read = 1'b1;
    cpu_address = AW'(5);
    #1;
    chk("cpu_waitrequest_during_rd", 32'(cpu_waitrequest), 32'(1));
    @(negedge clk);
    #1;
    chk("cpu_waitrequest_after_rd", 32'(cpu_waitrequest), 32'(0));
    ce.due = cyc + 2;
    ce.data = ref_mem[5];
    cq.push_back(ce);
    @(negedge clk);
    cpu_read = 1'b0;
    wait_until(e0 + 4);

    // reset asserted in the WR cycle aborts the write
    jtag_load(7, 1'b0, 1'b0, 1'b0, 1'b0);
    jtag_write(32'h77);
    jtag_load(7, 1'b0, 1'b0, 1'b0, 1'b0);
    start_pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h55), e0);
    end_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cpu_read = 1'b1;
    #1;
    chk("abort_cpu_waitrequest", 32'(cpu_waitrequest), 32'(0));
    #1;
    cpu_read = 1'b0;
    chk("abort_MonDReg", MonDReg, 32'h0);
    chk("abort_monitor_ready", 32'(monitor_ready), 32'(0));
    chk("abort_monitor_error", 32'(monitor_error), 32'(0));
    chk("abort_cpu_readdata", cpu_readdata, 32'h0);
    chk("abort_cpu_readdatavalid", 32'(cpu_readdatavalid), 32'(0));
    ref_addr = 0;
    ref_err = 1'b0;
    ref_dreg = 32'h0;
    jtag_load(7, 1'b1, 1'b0, 1'b0, 1'b0);
    jtag_load(6, 1'b1, 1'b0, 1'b0, 1'b0);

    // random concurrent traffic: JTAG writes only 128..255, CPU reads 0..127
    jtag_load(128, 1'b0, 1'b1, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          int r;
          int a;
          r = $urandom_range(0, 9);
          if (r <= 2) begin
            if (ref_addr >= 128) jtag_write($urandom());
            else jtag_load($urandom_range(128, 255), 1'b0, 1'b0, 1'b0, 1'b0);
          end else if (r <= 4) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 1023) : $urandom_range(0, 255);
            jtag_load(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      1'b0, 1'b0);
          end else if (r <= 7) begin
            jtag_next();
          end else begin
            jtag_load($urandom_range(0, 255), 1'b1, 1'b0, 1'b0, 1'b0);
          end
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 1) == 1) cpu_read_op(AW'($urandom_range(0, 127)));
          else cpu_cycle(1'b0, AW'($urandom_range(0, 255)), acc);
        end
        @(negedge clk);
        cpu_read = 1'b0;
      end
    join

    repeat (6) @(negedge clk);
    chk("jtag_queue_drained", 32'(jq.size()), 32'(0));
    chk("cpu_queue_drained", 32'(cq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
